// File: rtl/morse_pkg.sv
// Shared types and code-table constants for the Morse key entry controller.
// Each code-table entry is {element count, element bits}; element i sits in bit i, 1 = dash.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    GAP    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam logic [2:0] MAX_ELEM = 3'd5;

  localparam logic [7:0] SYM_0 = {3'd5, 5'b11111};
  localparam logic [7:0] SYM_1 = {3'd5, 5'b11110};
  localparam logic [7:0] SYM_2 = {3'd5, 5'b11100};
  localparam logic [7:0] SYM_3 = {3'd5, 5'b11000};
  localparam logic [7:0] SYM_4 = {3'd5, 5'b10000};
  localparam logic [7:0] SYM_5 = {3'd5, 5'b00000};
  localparam logic [7:0] SYM_6 = {3'd5, 5'b00001};
  localparam logic [7:0] SYM_7 = {3'd5, 5'b00011};
  localparam logic [7:0] SYM_8 = {3'd5, 5'b00111};
  localparam logic [7:0] SYM_9 = {3'd5, 5'b01111};
  localparam logic [7:0] SYM_A = {3'd2, 5'b00010};
  localparam logic [7:0] SYM_B = {3'd4, 5'b00001};
  localparam logic [7:0] SYM_C = {3'd4, 5'b00101};
  localparam logic [7:0] SYM_D = {3'd3, 5'b00001};
  localparam logic [7:0] SYM_E = {3'd1, 5'b00000};
  localparam logic [7:0] SYM_F = {3'd4, 5'b00100};

  // Keeps only the element bits that have actually been captured.
  function automatic logic [4:0] elem_mask(input logic [2:0] n);
    logic [4:0] m;
    case (n)
      3'd0:    m = 5'b00000;
      3'd1:    m = 5'b00001;
      3'd2:    m = 5'b00011;
      3'd3:    m = 5'b00111;
      3'd4:    m = 5'b01111;
      default: m = 5'b11111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse symbol decoder: maps captured elements to a hex digit.
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] elem_cnt,
  input  logic [4:0] elem_bits,
  output logic       valid,
  output logic [3:0] code
);

  logic [7:0] sym_s;

  // Table lookup; anything not in the table is reported invalid.
  always_comb begin
    sym_s = {elem_cnt, elem_bits & elem_mask(elem_cnt)};
    valid = 1'b1;
    code  = 4'h0;
    case (sym_s)
      SYM_0:   code = 4'h0;
      SYM_1:   code = 4'h1;
      SYM_2:   code = 4'h2;
      SYM_3:   code = 4'h3;
      SYM_4:   code = 4'h4;
      SYM_5:   code = 4'h5;
      SYM_6:   code = 4'h6;
      SYM_7:   code = 4'h7;
      SYM_8:   code = 4'h8;
      SYM_9:   code = 4'h9;
      SYM_A:   code = 4'hA;
      SYM_B:   code = 4'hB;
      SYM_C:   code = 4'hC;
      SYM_D:   code = 4'hD;
      SYM_E:   code = 4'hE;
      SYM_F:   code = 4'hF;
      default: begin
        valid = 1'b0;
        code  = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/morse_entry_ctrl.sv
// Morse key entry controller: times presses into dots/dashes, decodes a symbol after a
// letter gap and commits the hex digit to the display buffer. LONGPRESS_BS_EN adds long-press backspace.
module morse_entry_ctrl
  import morse_pkg::*;
#(
  parameter int unsigned CNT_W      = 28,
  parameter int unsigned MIN_PRESS  = 1_000_000,
  parameter int unsigned DASH_MIN   = 25_000_000,
  parameter int unsigned LETTER_GAP = 60_000_000,
  parameter int unsigned BS_HOLD    = 150_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic       buf_full,
  input  logic       commit_ready,
  output logic       commit_valid,
  output logic [3:0] commit_code,
  output logic       bs_req,
  output logic       err,
  output logic [2:0] elem_cnt,
  output logic [4:0] elem_bits
);

  localparam logic [CNT_W-1:0] MIN_PRESS_C = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0] DASH_MIN_C  = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] GAP_END_C   = CNT_W'(LETTER_GAP - 1);
`ifdef LONGPRESS_BS_EN
  localparam logic [CNT_W-1:0] BS_HOLD_C   = CNT_W'(BS_HOLD);
`endif

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] dur_s;
  logic [2:0]       elem_cnt_r;
  logic [4:0]       elem_bits_r;
  logic [3:0]       code_r;
  logic             commit_valid_r, bs_r, err_r;
  logic             elem_clr_s, elem_add_s, add_bit_s, code_load_s, bs_nxt_s, err_nxt_s;
  logic             lut_valid_s;
  logic [3:0]       lut_code_s;

  morse_lut u_lut (
    .elem_cnt  (elem_cnt_r),
    .elem_bits (elem_bits_r),
    .valid     (lut_valid_s),
    .code      (lut_code_s)
  );

  // The counter missed the first key-high cycle (sampled in IDLE/GAP), so add it back.
  assign dur_s = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);

  // Next-state and per-cycle decisions.
  always_comb begin
    state_nxt   = state_r;
    elem_clr_s  = 1'b0;
    elem_add_s  = 1'b0;
    add_bit_s   = DOT;
    code_load_s = 1'b0;
    bs_nxt_s    = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (key) state_nxt = PRESS;
        else     state_nxt = IDLE;
      end
      PRESS: begin
        if (key) begin
          state_nxt = PRESS;
        end else if (dur_s < MIN_PRESS_C) begin
          state_nxt = (elem_cnt_r != 3'd0) ? GAP : IDLE;
`ifdef LONGPRESS_BS_EN
        end else if (dur_s >= BS_HOLD_C) begin
          bs_nxt_s   = 1'b1;
          elem_clr_s = 1'b1;
          state_nxt  = IDLE;
`endif
        end else if (elem_cnt_r == MAX_ELEM) begin
          err_nxt_s  = 1'b1;
          elem_clr_s = 1'b1;
          state_nxt  = IDLE;
        end else begin
          elem_add_s = 1'b1;
          add_bit_s  = (dur_s >= DASH_MIN_C) ? DASH : DOT;
          state_nxt  = GAP;
        end
      end
      GAP: begin
        if (key) begin
          state_nxt = PRESS;
        end else if (cnt_r == GAP_END_C) begin
          if (lut_valid_s && !buf_full) begin
            code_load_s = 1'b1;
            state_nxt   = COMMIT;
          end else begin
            err_nxt_s  = 1'b1;
            elem_clr_s = 1'b1;
            state_nxt  = IDLE;
          end
        end else begin
          state_nxt = GAP;
        end
      end
      COMMIT: begin
        if (commit_ready) begin
          elem_clr_s = 1'b1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = COMMIT;
        end
      end
      default: begin
        elem_clr_s = 1'b1;
        state_nxt  = IDLE;
      end
    endcase
  end

  // State, duration counter, element store and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      elem_cnt_r     <= 3'd0;
      elem_bits_r    <= 5'b00000;
      code_r         <= 4'h0;
      commit_valid_r <= 1'b0;
      bs_r           <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (state_nxt != state_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == PRESS || state_r == GAP) && !(&cnt_r)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (elem_clr_s) begin
        elem_cnt_r  <= 3'd0;
        elem_bits_r <= 5'b00000;
      end else if (elem_add_s) begin
        elem_cnt_r              <= elem_cnt_r + 3'd1;
        elem_bits_r[elem_cnt_r] <= add_bit_s;
      end else begin
        elem_cnt_r  <= elem_cnt_r;
        elem_bits_r <= elem_bits_r;
      end
      if (code_load_s) code_r <= lut_code_s;
      else             code_r <= code_r;
      commit_valid_r <= (state_nxt == COMMIT);
      bs_r           <= bs_nxt_s;
      err_r          <= err_nxt_s;
    end
  end

  assign commit_valid = commit_valid_r;
  assign commit_code  = code_r;
  assign bs_req       = bs_r;
  assign err          = err_r;
  assign elem_cnt     = elem_cnt_r;
  assign elem_bits    = elem_bits_r;

endmodule

// File: tb/tb_morse_entry_ctrl.sv
// Directed self-checking bench for morse_entry_ctrl with short timing parameters.
// Expectations for the long press depend on LONGPRESS_BS_EN.
module tb_morse_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst, key, buf_full, commit_ready;
  logic       commit_valid, bs_req, err;
  logic [3:0] commit_code;
  logic [2:0] elem_cnt;
  logic [4:0] elem_bits;

  int n_checks = 0;
  int n_pass   = 0;
  int bs_seen = 0, err_seen = 0, commit_seen = 0;
  int s_err, s_commit, stable;

  morse_entry_ctrl #(
    .CNT_W(8), .MIN_PRESS(2), .DASH_MIN(10), .LETTER_GAP(20), .BS_HOLD(40)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .buf_full(buf_full), .commit_ready(commit_ready),
    .commit_valid(commit_valid), .commit_code(commit_code), .bs_req(bs_req), .err(err),
    .elem_cnt(elem_cnt), .elem_bits(elem_bits)
  );

  always #5 clk = ~clk;

  // Event tallies observed mid-cycle.
  always @(negedge clk) begin
    if (bs_req) bs_seen++;
    if (err) err_seen++;
    if (commit_valid && commit_ready) commit_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    else n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    key = 1'b1;
    step(n);
    key = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; key = 1'b0; buf_full = 1'b0; commit_ready = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Enters a symbol (dot = 4 cycles, dash = 12, 3-cycle gaps) and ends on the release edge.
  task automatic send_sym(input logic [4:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      press(bits[i] ? 12 : 4);
      if (i < len - 1) step(3);
    end
    step(1);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", commit_valid, 1'b0);
    chk("rst_code", commit_code, 4'h0);
    chk("rst_cnt", elem_cnt, 3'd0);
    chk("rst_bits", elem_bits, 5'd0);
    chk("rst_err_bs", {err, bs_req}, 2'b00);

    // A = .- ; commit_valid exactly LETTER_GAP+1 cycles after release
    send_sym(5'b00010, 2);
    chk("A_cnt", elem_cnt, 3'd2);
    chk("A_bits", elem_bits, 5'b00010);
    s_commit = commit_seen;
    step(19);
    chk("A_early", commit_valid, 1'b0);
    step(1);
    chk("A_valid", commit_valid, 1'b1);
    chk("A_code", commit_code, 4'hA);
    step(1);
    chk("A_accept", commit_seen - s_commit, 1);
    chk("A_drop", commit_valid, 1'b0);

    // 0 = ----- held off by commit_ready=0 for 7 cycles
    do_reset();
    commit_ready = 1'b0;
    send_sym(5'b11111, 5);
    chk("Z_bits", {elem_cnt, elem_bits}, {3'd5, 5'b11111});
    step(20);
    chk("Z_valid", commit_valid, 1'b1);
    stable = 1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (!(commit_valid === 1'b1 && commit_code === 4'h0)) stable = 0;
    end
    chk("Z_stable", stable, 1);
    chk("Z_code", commit_code, 4'h0);
    commit_ready = 1'b1;
    step(1);
    chk("Z_drop", commit_valid, 1'b0);

    // 45-cycle press
    do_reset();
    s_commit = commit_seen;
    press(45);
    step(1);
`ifdef LONGPRESS_BS_EN
    chk("BS_pulse", bs_req, 1'b1);
    chk("BS_cnt", elem_cnt, 3'd0);
    step(1);
    chk("BS_once", bs_req, 1'b0);
    s_err = err_seen;
    step(25);
    chk("BS_noerr", err_seen - s_err, 0);
`else
    chk("LP_dash", {elem_cnt, elem_bits}, {3'd1, 5'b00001});
    chk("LP_nobs", bs_req, 1'b0);
    step(20);
    chk("LP_err", err, 1'b1);
    step(1);
    chk("LP_err_once", err, 1'b0);
`endif
    chk("LP_nocommit", commit_seen - s_commit, 0);

    // Press-length boundaries: 2 cycles accepted as dot, 10 cycles is a dash
    do_reset();
    press(2);
    step(1);
    chk("MIN_accept", {elem_cnt, elem_bits}, {3'd1, 5'b00000});
    step(2);
    press(9);
    step(1);
    chk("DOT_9", {elem_cnt, elem_bits}, {3'd2, 5'b00000});
    step(2);
    press(10);
    step(1);
    chk("DASH_10", {elem_cnt, elem_bits}, {3'd3, 5'b00100});

    // Six dots: err on the sixth release
    do_reset();
    send_sym(5'b00000, 5);
    step(2);
    chk("SIX_pre", elem_cnt, 3'd5);
    s_commit = commit_seen;
    press(4);
    step(1);
    chk("SIX_err", err, 1'b1);
    chk("SIX_clr", elem_cnt, 3'd0);
    step(1);
    chk("SIX_err_once", err, 1'b0);
    step(25);
    chk("SIX_nocommit", commit_seen - s_commit, 0);

    // Glitch between dots: ignored and gap restarts -> E after LETTER_GAP+1
    do_reset();
    press(4);
    step(6);
    press(1);
    step(1);
    chk("GL_cnt", {elem_cnt, elem_bits}, {3'd1, 5'b00000});
    step(19);
    chk("GL_early", commit_valid, 1'b0);
    step(1);
    chk("GL_valid", commit_valid, 1'b1);
    chk("GL_code", commit_code, 4'hE);

    // buf_full at decode of .----
    do_reset();
    s_commit = commit_seen;
    send_sym(5'b11110, 5);
    buf_full = 1'b1;
    step(20);
    chk("BF_err", err, 1'b1);
    chk("BF_novalid", commit_valid, 1'b0);
    buf_full = 1'b0;
    step(3);
    chk("BF_nocommit", commit_seen - s_commit, 0);

    // Commit a 1, then reset mid-GAP of the next symbol
    do_reset();
    send_sym(5'b11110, 5);
    step(20);
    chk("ONE_code", {commit_valid, commit_code}, {1'b1, 4'h1});
    step(1);
    press(12);
    step(4);
    rst = 1'b1;
    step(1);
    chk("RST_outs", {commit_valid, commit_code, bs_req, err, elem_cnt, elem_bits}, 15'd0);
    rst = 1'b0;
    s_err = err_seen;
    s_commit = commit_seen;
    step(30);
    chk("RST_quiet", (err_seen - s_err) + (commit_seen - s_commit), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
